// File: rtl/uart_hex_tx_if.sv
// Byte-input handshake between a producer and the hex-report UART transmitter.
interface uart_hex_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_hex_tx.sv
// Serial hex reporter: each accepted byte is sent on the UART line as two
// uppercase ASCII hex digits followed by CR LF, characters back-to-back.
module uart_hex_tx #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BIT_RATE  = 9600,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          resetn,
    uart_hex_tx_if.slave  bus,
    output logic          uart_txd,
    output logic          busy
);

    localparam int CPB    = CLK_HZ / BIT_RATE;
    localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [2:0]        BIT_LAST  = 3'd7;
    localparam logic [1:0]        CHAR_LAST = 2'd3;

    if (CPB < 2) begin : g_cpb_check
        $fatal(1, "uart_hex_tx: CLK_HZ/BIT_RATE must be at least 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_check
        $fatal(1, "uart_hex_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ASCII code of one nibble, uppercase A-F.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] code;
        if (nib < 4'd10) begin
            code = 8'h30 + {4'h0, nib};
        end else begin
            code = 8'h37 + {4'h0, nib};
        end
        return code;
    endfunction

    // Character number idx of the message reporting byte b.
    function automatic logic [7:0] msg_char(input logic [1:0] idx, input logic [7:0] b);
        logic [7:0] ch;
        case (idx)
            2'd0:    ch = hex_char(b[7:4]);
            2'd1:    ch = hex_char(b[3:0]);
            2'd2:    ch = 8'h0D;
            default: ch = 8'h0A;
        endcase
        return ch;
    endfunction

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit;      // data bit index, reused as stop-bit index
    logic [1:0]          r_char;
    logic [7:0]          r_byte;
    logic [7:0]          r_shift;    // remaining bits of the current character
    logic                r_txd;
    logic                r_in_ready;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [2:0]          w_bit_nxt;
    logic [1:0]          w_char_nxt;
    logic [7:0]          w_byte_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_txd_nxt;
    logic                w_baud_end;

    assign w_baud_end   = (r_baud == BAUD_LAST);
    assign bus.in_ready = r_in_ready;
    assign uart_txd     = r_txd;
    assign busy         = r_busy;

    // Next-state, counter and line-level decode; the line value is computed
    // one cycle ahead so the registered output changes exactly on bit edges.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_char_nxt  = r_char;
        w_byte_nxt  = r_byte;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (bus.in_valid && r_in_ready) begin
                    w_byte_nxt  = bus.in_data;
                    w_shift_nxt = msg_char(2'd0, bus.in_data);
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_char_nxt  = 2'd0;
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt  = r_baud + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt   = 3'd0;
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_txd_nxt   = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_bit_nxt = 3'd0;
                        if (r_char == CHAR_LAST) begin
                            w_char_nxt  = 2'd0;
                            w_txd_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_char_nxt  = r_char + 2'd1;
                            w_shift_nxt = msg_char(r_char + 2'd1, r_byte);
                            w_txd_nxt   = 1'b0;
                            w_state_nxt = S_START;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = 3'd0;
                w_char_nxt  = 2'd0;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any message.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= 3'd0;
            r_char     <= 2'd0;
            r_byte     <= 8'h00;
            r_shift    <= 8'h00;
            r_txd      <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit      <= w_bit_nxt;
            r_char     <= w_char_nxt;
            r_byte     <= w_byte_nxt;
            r_shift    <= w_shift_nxt;
            r_txd      <= w_txd_nxt;
            r_in_ready <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: two instances (one and two stop bits) share the
// stimulus; a timing model predicts readiness and the expected characters,
// and a line decoder per instance checks every received frame.
module tb_uart_hex_tx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic       drv_valid;
    logic [7:0] drv_data;

    uart_hex_tx_if if_a ();
    uart_hex_tx_if if_b ();

    logic txd_a, txd_b, busy_a, busy_b;
    logic [1:0] txd_s, rdy_s, busy_s;

    assign if_a.in_valid = drv_valid;
    assign if_a.in_data  = drv_data;
    assign if_b.in_valid = drv_valid;
    assign if_b.in_data  = drv_data;
    assign txd_s  = {txd_b, txd_a};
    assign rdy_s  = {if_b.in_ready, if_a.in_ready};
    assign busy_s = {busy_b, busy_a};

    uart_hex_tx #(.CLK_HZ(10), .BIT_RATE(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .resetn(resetn), .bus(if_a), .uart_txd(txd_a), .busy(busy_a));
    uart_hex_tx #(.CLK_HZ(10), .BIT_RATE(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .resetn(resetn), .bus(if_b), .uart_txd(txd_b), .busy(busy_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected characters: bit 8 marks the first character of a message.
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    bit         ready_m[2];
    int         busy_left[2];
    bit         inframe[2];
    int         cnt[2];
    logic [7:0] sh[2];
    int         prev_start[2];

    string HEX = "0123456789ABCDEF";

    function automatic int frame_len(int d);
        return (9 + d + 1) * CPB;
    endfunction

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic q_push(int d, logic [8:0] v);
        if (d == 0) q_a.push_back(v); else q_b.push_back(v);
    endtask

    function automatic int q_size(int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic logic [8:0] q_head(int d);
        return (d == 0) ? q_a[0] : q_b[0];
    endfunction

    task automatic q_pop(int d, output logic [8:0] v);
        if (d == 0) v = q_a.pop_front(); else v = q_b.pop_front();
    endtask

    task automatic q_flush(int d);
        if (d == 0) q_a.delete(); else q_b.delete();
    endtask

    task automatic push_msg(int d, logic [7:0] b);
        logic [7:0] hi, lo;
        hi = HEX[b[7:4]];
        lo = HEX[b[3:0]];
        q_push(d, {1'b1, hi});
        q_push(d, {1'b0, lo});
        q_push(d, {1'b0, 8'h0D});
        q_push(d, {1'b0, 8'h0A});
    endtask

    // Model step for the edge just taken, then compare outputs and decode the line.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bit acc;
            acc = 1'b0;
            if (!resetn) begin
                ready_m[d]   = 1'b0;
                busy_left[d] = 0;
                inframe[d]   = 1'b0;
                q_flush(d);
            end else if (ready_m[d] && drv_valid) begin
                acc          = 1'b1;
                ready_m[d]   = 1'b0;
                busy_left[d] = 4 * frame_len(d);
                push_msg(d, drv_data);
            end else if (!ready_m[d]) begin
                if (busy_left[d] > 0) busy_left[d]--;
                if (busy_left[d] == 0) ready_m[d] = 1'b1;
            end

            check("in_ready", d, 32'(rdy_s[d]), 32'(ready_m[d]));
            check("busy", d, 32'(busy_s[d]), 32'(busy_left[d] > 0));
            if (busy_left[d] == 0) check("idle_line", d, 32'(txd_s[d]), 32'd1);
            if (acc) check("start_latency", d, 32'(txd_s[d]), 32'd0);

            if (resetn) begin
                if (!inframe[d]) begin
                    if (txd_s[d] == 1'b0) begin
                        inframe[d] = 1'b1;
                        cnt[d]     = 0;
                        if (q_size(d) == 0) begin
                            check("unexpected_start", d, 32'd1, 32'd0);
                        end else if (!q_head(d)[8]) begin
                            check("char_spacing", d, 32'(cyc - prev_start[d]), 32'(frame_len(d)));
                        end
                        prev_start[d] = cyc;
                    end
                end else begin
                    cnt[d]++;
                    if ((cnt[d] % CPB) == (CPB / 2)) begin
                        int k;
                        k = cnt[d] / CPB;
                        if (k == 0) begin
                            check("start_bit", d, 32'(txd_s[d]), 32'd0);
                        end else if (k <= 8) begin
                            sh[d][k-1] = txd_s[d];
                        end else begin
                            check("stop_bit", d, 32'(txd_s[d]), 32'd1);
                            if (k == 8 + d + 1) begin
                                logic [8:0] e;
                                inframe[d] = 1'b0;
                                if (q_size(d) == 0) begin
                                    check("extra_char", d, 32'(sh[d]), 32'h1FF);
                                end else begin
                                    q_pop(d, e);
                                    check("char", d, 32'(sh[d]), 32'(e[7:0]));
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Wait until both instances are ready; optionally poke random ignored
    // traffic while both are busy.
    task automatic wait_both_idle(bit noise);
        int guard;
        guard = 0;
        while (!(rdy_s == 2'b11) && guard < 3000) begin
            if (noise && rdy_s == 2'b00) begin
                drv_valid = 1'($urandom_range(0, 1));
                drv_data  = 8'($urandom);
            end else begin
                drv_valid = 1'b0;
            end
            tick();
            guard++;
        end
        drv_valid = 1'b0;
        if (guard >= 3000) check("idle_timeout", 0, 32'(rdy_s), 32'h3);
    endtask

    task automatic send(logic [7:0] b, bit noise);
        wait_both_idle(noise);
        drv_valid = 1'b1;
        drv_data  = b;
        tick();
        drv_valid = 1'b0;
        drv_data  = 8'($urandom);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ready_m[d] = 1'b0; busy_left[d] = 0; inframe[d] = 1'b0;
            cnt[d] = 0; sh[d] = 8'h00; prev_start[d] = 0;
        end
        resetn    = 1'b0;
        drv_valid = 1'b0;
        drv_data  = 8'h00;
        repeat (5) tick();
        resetn = 1'b1;
        repeat (4) tick();

        send(8'h3A, 1'b0);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);

        // Held valid with data changing mid-message.
        wait_both_idle(1'b0);
        drv_valid = 1'b1;
        drv_data  = 8'h12;
        repeat (51) tick();
        drv_data = 8'h34;
        repeat (850) tick();
        drv_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 20)) tick();
            send(8'($urandom), 1'b1);
        end

        // Abort a message with reset, then send a clean one.
        send(8'hC3, 1'b0);
        repeat (149) tick();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        send(8'hA5, 1'b0);
        send(8'h7E, 1'b0);

        wait_both_idle(1'b0);
        repeat (20) tick();
        check("pending_chars", 0, 32'(q_a.size()), 32'd0);
        check("pending_chars", 1, 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
